pipelined_controller: RTL

- Next-generation RISC-V (RV32I) control unit for the pipelined core.
- Decodes the instruction in ID.
- Carries control fields through the ID/EX, EX/MEM and MEM/WB control registers.
- Resolves all six branch conditions plus jal/jalr in EX.
- Generates load-use stall and branch/jump flush signals.
- Widths of the ALU-control field and the register address are parametrised.

---
 rtl/pipelined_controller.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_controller.sv
// rtl/pipelined_controller.sv - RV32I pipelined control unit: ID decode, EX/MEM/WB control registers, branch resolve, hazards
//
// Purpose:
//   Decodes the instruction sitting in ID, carries its control fields down the
//   ID/EX -> EX/MEM -> MEM/WB control registers, resolves branches and jumps in
//   EX, and produces the load-use stall and branch/jump flush signals.
//
// Parameters:
//   ALUCTRL_W   ALU control width (4 = full RV32I op set, 3 = add/sub/and/or/slt)
//   FULL_BRANCH 1 = all six branch conditions, 0 = beq/bne only
//   RADDR_W     register address width
//
// Ports:
//   clk, reset                   rising-edge clock, asynchronous active-high reset
//   opD, funct3D, funct7b5D      instruction fields in ID
//   Rs1D, Rs2D                   source registers in ID (load-use compare)
//   RdE                          destination register in EX (from datapath)
//   ZeroE, LtE, LtuE             ALU flags in EX
//   ImmSrcD, IllegalD            ID outputs
//   ALUControlE, ALUSrcE         EX ALU controls
//   PCSrcE, PCTargetSrcE         EX PC redirect and target select
//   MemWriteM, RegWriteM         MEM controls
//   RegWriteW, ResultSrcW        WB controls
//   StallF, StallD, FlushD, FlushE  hazard controls

module pipelined_controller #(
    parameter int ALUCTRL_W   = 4,
    parameter int FULL_BRANCH = 1,
    parameter int RADDR_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opD,
    input  logic [2:0]           funct3D,
    input  logic                 funct7b5D,
    input  logic [RADDR_W-1:0]   Rs1D,
    input  logic [RADDR_W-1:0]   Rs2D,
    input  logic [RADDR_W-1:0]   RdE,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic [2:0]           ImmSrcD,
    output logic                 IllegalD,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 PCSrcE,
    output logic                 PCTargetSrcE,
    output logic                 MemWriteM,
    output logic                 RegWriteM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // The 3-bit ALU codes are exactly the low bits of the 4-bit ones for the
    // ops that survive in the reduced set, so one 4-bit table serves both.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // ------------------------------------------------------------------
    // ID: ALU operation decode for R-type and I-type ALU instructions
    // ------------------------------------------------------------------
    logic       is_rtype;
    logic [3:0] arith_op;
    logic       arith_bad;

    assign is_rtype = (opD == OP_RTYPE);

    always_comb begin
        arith_op  = ALU_ADD;
        arith_bad = 1'b0;
        case (funct3D)
            3'b000: arith_op = (is_rtype && funct7b5D) ? ALU_SUB : ALU_ADD;
            3'b001: begin
                arith_op  = ALU_SLL;
                arith_bad = funct7b5D;      // sll/slli with instr[30] set is not RV32I
            end
            3'b010: arith_op = ALU_SLT;
            3'b011: arith_op = ALU_SLTU;
            3'b100: arith_op = ALU_XOR;
            3'b101: arith_op = funct7b5D ? ALU_SRA : ALU_SRL;
            3'b110: arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
        // instr[30] is only meaningful on R-type for sub and sra
        if (is_rtype && funct7b5D && (funct3D != 3'b000) && (funct3D != 3'b101))
            arith_bad = 1'b1;
        if ((ALUCTRL_W < 4) &&
            (arith_op inside {ALU_XOR, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA}))
            arith_bad = 1'b1;
    end

    logic branch_f3_ok;
    assign branch_f3_ok = (FULL_BRANCH != 0) ? (funct3D[2:1] != 2'b01)
                                             : (funct3D[2:1] == 2'b00);

    // ------------------------------------------------------------------
    // ID: main decode
    // ------------------------------------------------------------------
    logic       reg_write_d;
    logic [1:0] result_src_d;
    logic       mem_write_d;
    logic       branch_d;
    logic       jump_d;
    logic       jalr_d;
    logic       alu_src_d;
    logic [2:0] imm_src_d;
    logic [3:0] alu_op_d;
    logic       illegal_d;

    always_comb begin
        reg_write_d  = 1'b0;
        result_src_d = 2'b00;
        mem_write_d  = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        jalr_d       = 1'b0;
        alu_src_d    = 1'b0;
        imm_src_d    = 3'b000;
        alu_op_d     = ALU_ADD;
        illegal_d    = 1'b0;
        case (opD)
            OP_LOAD: begin
                reg_write_d  = 1'b1;
                result_src_d = 2'b01;
                alu_src_d    = 1'b1;
                illegal_d    = (funct3D != 3'b010);   // only lw
            end
            OP_STORE: begin
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
                imm_src_d   = 3'b001;
                illegal_d   = (funct3D != 3'b010);    // only sw
            end
            OP_RTYPE: begin
                reg_write_d = 1'b1;
                alu_op_d    = arith_op;
                illegal_d   = arith_bad;
            end
            OP_ITYPE: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_op_d    = arith_op;
                illegal_d   = arith_bad;
            end
            OP_BRANCH: begin
                branch_d  = 1'b1;
                imm_src_d = 3'b010;
                alu_op_d  = ALU_SUB;
                illegal_d = !branch_f3_ok;
            end
            OP_JAL: begin
                reg_write_d  = 1'b1;
                result_src_d = 2'b10;
                jump_d       = 1'b1;
                imm_src_d    = 3'b011;
            end
            OP_JALR: begin
                reg_write_d  = 1'b1;
                result_src_d = 2'b10;
                jump_d       = 1'b1;
                jalr_d       = 1'b1;
                alu_src_d    = 1'b1;
                illegal_d    = (funct3D != 3'b000);
            end
            OP_LUI: begin
                reg_write_d  = 1'b1;
                result_src_d = 2'b11;
                alu_src_d    = 1'b1;
                imm_src_d    = 3'b100;
            end
            default: illegal_d = 1'b1;
        endcase
        // An illegal instruction travels down the pipe as a NOP. ResultSrc is
        // cleared too so a malformed load cannot raise a load-use stall.
        if (illegal_d) begin
            reg_write_d  = 1'b0;
            result_src_d = 2'b00;
            mem_write_d  = 1'b0;
            branch_d     = 1'b0;
            jump_d       = 1'b0;
            jalr_d       = 1'b0;
        end
    end

    assign ImmSrcD  = imm_src_d;
    assign IllegalD = illegal_d;

    // ------------------------------------------------------------------
    // ID/EX control register (flush inserts an all-zero bubble, never stalls)
    // ------------------------------------------------------------------
    logic                 reg_write_e;
    logic [1:0]           result_src_e;
    logic                 mem_write_e;
    logic                 branch_e;
    logic                 jump_e;
    logic                 jalr_e;
    logic [ALUCTRL_W-1:0] alu_ctrl_e;
    logic                 alu_src_e;
    logic [2:0]           funct3_e;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || FlushE) begin
            reg_write_e  <= 1'b0;
            result_src_e <= 2'b00;
            mem_write_e  <= 1'b0;
            branch_e     <= 1'b0;
            jump_e       <= 1'b0;
            jalr_e       <= 1'b0;
            alu_ctrl_e   <= '0;
            alu_src_e    <= 1'b0;
            funct3_e     <= 3'b000;
        end else begin
            reg_write_e  <= reg_write_d;
            result_src_e <= result_src_d;
            mem_write_e  <= mem_write_d;
            branch_e     <= branch_d;
            jump_e       <= jump_d;
            jalr_e       <= jalr_d;
            alu_ctrl_e   <= alu_op_d[ALUCTRL_W-1:0];
            alu_src_e    <= alu_src_d;
            funct3_e     <= funct3D;
        end
    end

    // ------------------------------------------------------------------
    // EX: branch resolution
    // ------------------------------------------------------------------
    logic branch_cond;

    always_comb begin
        branch_cond = 1'b0;
        case (funct3_e)
            3'b000:  branch_cond = ZeroE;
            3'b001:  branch_cond = !ZeroE;
            3'b100:  branch_cond = LtE;
            3'b101:  branch_cond = !LtE;
            3'b110:  branch_cond = LtuE;
            3'b111:  branch_cond = !LtuE;
            default: branch_cond = 1'b0;
        endcase
    end

    assign PCSrcE       = (branch_e && branch_cond) || jump_e;
    assign PCTargetSrcE = jalr_e;
    assign ALUControlE  = alu_ctrl_e;
    assign ALUSrcE      = alu_src_e;

    // ------------------------------------------------------------------
    // EX/MEM and MEM/WB control registers (always advance)
    // ------------------------------------------------------------------
    logic       reg_write_m;
    logic [1:0] result_src_m;
    logic       mem_write_m;
    logic       reg_write_w;
    logic [1:0] result_src_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            mem_write_m  <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
        end else begin
            reg_write_m  <= reg_write_e;
            result_src_m <= result_src_e;
            mem_write_m  <= mem_write_e;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
        end
    end

    assign MemWriteM  = mem_write_m;
    assign RegWriteM  = reg_write_m;
    assign RegWriteW  = reg_write_w;
    assign ResultSrcW = result_src_w;

    // ------------------------------------------------------------------
    // Hazards. Both source fields are compared for every instruction; a false
    // match on an unused rs2 only costs one bubble.
    // ------------------------------------------------------------------
    logic lw_stall;

    assign lw_stall = (result_src_e == 2'b01) && (RdE != '0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    assign StallF = lw_stall;
    assign StallD = lw_stall;
    assign FlushD = PCSrcE;
    assign FlushE = lw_stall || PCSrcE;

endmodule
